// File: rtl/restore_state_pkg.sv
// Shared definitions for the context restore sequencer: state encoding,
// RAM direction codes and the fixed layout of the saved state header.
package restore_state_pkg;

  // Sequencer states; each LOAD_* state spans two cycles (phase 0 / phase 1).
  typedef enum logic [2:0] {
    IDLE,
    LOAD_POINTERS,
    LOAD_PC_ALU,
    LOAD_STACK_1,
    LOAD_STACK_2,
    LOAD_STACK_3,
    DONE
  } state_t;

  // RAM direction codes, common to the save and restore blocks.
  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  // Header word addresses.
  localparam int STATE_POINTERS_ADDR = 0;
  localparam int STATE_PC_ALU_ADDR   = 1;

  // The save side stores csp-2; restore adds it back.
  localparam int CALL_STACK_BIAS = 2;

  // Bit positions inside header word 1.
  localparam int FLAGS_LSB  = 12;
  localparam int FLAGS_BITS = 4;
  localparam int PC_LSB     = 0;
  localparam int PC_BITS    = 9;

  // Order in which the load states are walked.
  function automatic state_t load_successor(input state_t s);
    case (s)
      LOAD_POINTERS: return LOAD_PC_ALU;
      LOAD_PC_ALU:   return LOAD_STACK_1;
      LOAD_STACK_1:  return LOAD_STACK_2;
      LOAD_STACK_2:  return LOAD_STACK_3;
      LOAD_STACK_3:  return DONE;
      default:       return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/restore_state.sv
// Context restore sequencer: reads the saved header (pointers, PC, flags)
// and the three spilled top-of-stack words back from RAM and presents them
// as registered outputs to the core.
module restore_state
  import restore_state_pkg::*;
#(
  parameter int addrBits = 8,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [dataBits-1:0] dataOut,
  output logic [addrBits-1:0] address,
  output logic                rwMode,
  output logic                busy,
  output logic                finished,
  output logic [addrBits-1:0] stackPointer,
  output logic [addrBits-1:0] callStackPointer,
  output logic [8:0]          programCounter,
  output logic [3:0]          aluFlags,
  output logic [dataBits-1:0] topOfStack1,
  output logic [dataBits-1:0] topOfStack2,
  output logic [dataBits-1:0] topOfStack3
);

  state_t state;
  state_t state_next;
  logic   phase;
  logic   phase_next;

  // State and phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next-state logic: IDLE/DONE wait for start, load states take two cycles.
  always_comb begin
    state_next = state;
    phase_next = phase;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD_POINTERS;
          phase_next = 1'b0;
        end
      end
      default: begin
        if (phase) begin
          state_next = load_successor(state);
          phase_next = 1'b0;
        end else begin
          phase_next = 1'b1;
        end
      end
    endcase
  end

  // Read address from the current state and the already restored sp;
  // stack offsets wrap naturally at the address width.
  always_comb begin
    address = '0;
    case (state)
      LOAD_POINTERS: address = addrBits'(STATE_POINTERS_ADDR);
      LOAD_PC_ALU:   address = addrBits'(STATE_PC_ALU_ADDR);
      LOAD_STACK_1:  address = stackPointer;
      LOAD_STACK_2:  address = stackPointer + addrBits'(1);
      LOAD_STACK_3:  address = stackPointer + addrBits'(2);
      default:       address = '0;
    endcase
  end

  assign rwMode   = RAM_READ;
  assign busy     = (state != IDLE) && (state != DONE);
  assign finished = (state == DONE);

  // Field capture on the closing edge of phase 1; fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      stackPointer     <= '0;
      callStackPointer <= '0;
      programCounter   <= '0;
      aluFlags         <= '0;
      topOfStack1      <= '0;
      topOfStack2      <= '0;
      topOfStack3      <= '0;
    end else if (phase) begin
      case (state)
        LOAD_POINTERS: begin
          stackPointer     <= dataOut[2*addrBits-1:addrBits];
          callStackPointer <= dataOut[addrBits-1:0] + addrBits'(CALL_STACK_BIAS);
        end
        LOAD_PC_ALU: begin
          aluFlags       <= dataOut[FLAGS_LSB +: FLAGS_BITS];
          programCounter <= dataOut[PC_LSB +: PC_BITS];
        end
        LOAD_STACK_1: topOfStack1 <= dataOut;
        LOAD_STACK_2: topOfStack2 <= dataOut;
        LOAD_STACK_3: topOfStack3 <= dataOut;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restore_state.sv
// Self-checking bench for restore_state: a registered-read RAM model feeds
// the DUT, and expected outputs/addresses are derived from the RAM contents
// using the documented header layout.
module tb_restore_state;
  import restore_state_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dataOut;
  logic [7:0]  address;
  logic        rwMode;
  logic        busy;
  logic        finished;
  logic [7:0]  stackPointer;
  logic [7:0]  callStackPointer;
  logic [8:0]  programCounter;
  logic [3:0]  aluFlags;
  logic [15:0] topOfStack1;
  logic [15:0] topOfStack2;
  logic [15:0] topOfStack3;

  logic [15:0] mem [256];
  int errors = 0;
  int checks = 0;

  restore_state #(.addrBits(8), .dataBits(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dataOut(dataOut),
    .address(address), .rwMode(rwMode), .busy(busy), .finished(finished),
    .stackPointer(stackPointer), .callStackPointer(callStackPointer),
    .programCounter(programCounter), .aluFlags(aluFlags),
    .topOfStack1(topOfStack1), .topOfStack2(topOfStack2),
    .topOfStack3(topOfStack3)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read.
  always @(posedge clk) dataOut <= mem[address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sp"}, 32'(stackPointer), 0);
    check({tag, "_csp"}, 32'(callStackPointer), 0);
    check({tag, "_pc"}, 32'(programCounter), 0);
    check({tag, "_flags"}, 32'(aluFlags), 0);
    check({tag, "_tos"}, 32'({topOfStack1, topOfStack2, topOfStack3} != 48'h0), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_finished"}, 32'(finished), 0);
    check({tag, "_addr"}, 32'(address), 0);
  endtask

  // Runs one full restore and compares against values computed from RAM.
  // poke=1 pulses start mid-restore, which must have no effect.
  task automatic run_restore(input string tag, input bit poke);
    logic [7:0]  e_sp, e_csp;
    logic [8:0]  e_pc;
    logic [3:0]  e_flags;
    logic [15:0] w0, w1, e_t1, e_t2, e_t3;
    logic [7:0]  e_addr [10];
    w0      = mem[0];
    w1      = mem[1];
    e_sp    = w0 / 256;
    e_csp   = 8'((w0 % 256) + 2);
    e_flags = 4'(w1 / 4096);
    e_pc    = 9'(w1 % 512);
    e_t1    = mem[e_sp];
    e_t2    = mem[8'(e_sp + 1)];
    e_t3    = mem[8'(e_sp + 2)];
    for (int k = 0; k < 5; k++) begin
      logic [7:0] a;
      a = (k < 2) ? 8'(k) : 8'(e_sp + k - 2);
      e_addr[2*k]   = a;
      e_addr[2*k+1] = a;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("%s_addr%0d", tag, c), 32'(address), 32'(e_addr[c]));
      check($sformatf("%s_busy%0d", tag, c), 32'(busy), 1);
      check($sformatf("%s_fin%0d", tag, c), 32'(finished), 0);
      check($sformatf("%s_rw%0d", tag, c), 32'(rwMode), 32'(RAM_READ));
      start = (poke && c == 3);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({tag, "_finished"}, 32'(finished), 1);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_addr_end"}, 32'(address), 0);
    check({tag, "_sp"}, 32'(stackPointer), 32'(e_sp));
    check({tag, "_csp"}, 32'(callStackPointer), 32'(e_csp));
    check({tag, "_pc"}, 32'(programCounter), 32'(e_pc));
    check({tag, "_flags"}, 32'(aluFlags), 32'(e_flags));
    check({tag, "_tos1"}, 32'(topOfStack1), 32'(e_t1));
    check({tag, "_tos2"}, 32'(topOfStack2), 32'(e_t2));
    check({tag, "_tos3"}, 32'(topOfStack3), 32'(e_t3));
    $display("restore %s: sp=%h csp=%h pc=%h flags=%h tos=%h/%h/%h", tag,
             stackPointer, callStackPointer, programCounter, aluFlags,
             topOfStack1, topOfStack2, topOfStack3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);

    // Basic restore.
    mem[0] = 16'h4010; mem[1] = 16'hA105;
    mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222; mem[8'h42] = 16'h3333;
    run_restore("basic", 1'b0);
    check("basic_csp_abs", 32'(callStackPointer), 32'h12);
    check("basic_pc_abs", 32'(programCounter), 32'h105);

    // Start while DONE restarts immediately; start while busy is ignored.
    mem[0] = 16'hFFFE; mem[1] = 16'h5FFF;
    mem[8'hFF] = 16'hAAAA; mem[8'h00] = 16'hFFFE; mem[8'h01] = 16'h5FFF;
    run_restore("wrap", 1'b1);
    check("wrap_sp_abs", 32'(stackPointer), 32'hFF);
    check("wrap_csp_abs", 32'(callStackPointer), 32'h00);
    check("resv_flags_abs", 32'(aluFlags), 32'h5);
    check("resv_pc_abs", 32'(programCounter), 32'h1FF);

    // Reset during LOAD_STACK_2 aborts and clears everything.
    mem[0] = 16'h3007; mem[1] = 16'h7123;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_pre_addr", 32'(address), 32'h31);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("abort");
    $display("reset mid-restore: outputs cleared");
    run_restore("after_abort", 1'b0);

    // Round trip using the save-side layout.
    mem[0] = {8'h20, 8'(8'h35 - 8'd2)};
    mem[1] = {4'h3, 3'b000, 9'h0AB};
    mem[8'h20] = 16'hBEEF; mem[8'h21] = 16'hCAFE; mem[8'h22] = 16'h0001;
    run_restore("roundtrip", 1'b0);
    check("rt_sp", 32'(stackPointer), 32'h20);
    check("rt_csp", 32'(callStackPointer), 32'h35);
    check("rt_pc", 32'(programCounter), 32'h0AB);
    check("rt_flags", 32'(aluFlags), 32'h3);
    check("rt_tos", 32'({topOfStack1, topOfStack2, topOfStack3}), 32'hCAFE0001);
    check("rt_tos1", 32'(topOfStack1), 32'hBEEF);

    // Randomised restores.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_restore($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
